// File: rtl/max_uint16_reduce_ctrl.sv
// Streaming max-reduce controller: finds the maximum unsigned operand of a job
// and the index of its first occurrence, using one time-shared compare/select path.
module max_uint16_reduce_ctrl #(
   parameter  int WIDTH   = 16,
   parameter  int MAX_LEN = 256,
   localparam int LEN_W   = $clog2(MAX_LEN + 1),
   localparam int IDX_W   = $clog2(MAX_LEN)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [LEN_W-1:0] len,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             in_ready,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_max,
   output logic [IDX_W-1:0] out_idx,
   output logic             busy,
   output logic             err
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ACCUM = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;

   logic [LEN_W-1:0] r_len;
   logic [LEN_W-1:0] r_cnt;
   logic [WIDTH-1:0] r_max;
   logic [IDX_W-1:0] r_idx;
   logic             r_in_ready;
   logic             r_out_valid;
   logic             r_busy;
   logic             r_err;

   logic             w_len_ok;
   logic             w_idle_start;
   logic             w_accept;
   logic             w_illegal;
   logic             w_xfer;
   logic             w_last;
   logic             w_gt;
   logic             w_take;

   // Job launch qualification, element transfer and the compare/select decision
   always_comb begin
      w_len_ok     = 1'b0;
      w_idle_start = 1'b0;
      w_accept     = 1'b0;
      w_illegal    = 1'b0;
      w_xfer       = 1'b0;
      w_last       = 1'b0;
      w_gt         = 1'b0;
      w_take       = 1'b0;

      w_len_ok     = (len != {LEN_W{1'b0}}) && (len <= LEN_W'(MAX_LEN));
      w_idle_start = (r_state == S_IDLE) && start;
      w_accept     = w_idle_start && w_len_ok;
      w_illegal    = w_idle_start && !w_len_ok;
      // in_ready is exactly "state is ACCUM", so qualify on state directly
      w_xfer       = (r_state == S_ACCUM) && in_valid;
      w_last       = (r_cnt == (r_len - LEN_W'(1)));
      w_gt         = (in_data > r_max);
      // element 0 always loads; later elements load only on strictly greater
      w_take       = w_xfer && ((r_cnt == {LEN_W{1'b0}}) || w_gt);
   end

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               w_state_nxt = S_ACCUM;
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         S_ACCUM: begin
            if (w_xfer && w_last) begin
               w_state_nxt = S_DONE;
            end else begin
               w_state_nxt = S_ACCUM;
            end
         end
         S_DONE: begin
            if (out_ready) begin
               w_state_nxt = S_IDLE;
            end else begin
               w_state_nxt = S_DONE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Status flags registered from the next state so they line up with r_state
   always_ff @(posedge clk) begin
      if (rst) begin
         r_in_ready  <= 1'b0;
         r_out_valid <= 1'b0;
         r_busy      <= 1'b0;
         r_err       <= 1'b0;
      end else begin
         r_in_ready  <= (w_state_nxt == S_ACCUM);
         r_out_valid <= (w_state_nxt == S_DONE);
         r_busy      <= (w_state_nxt != S_IDLE);
         r_err       <= w_illegal;
      end
   end

   // Job length latch and element counter
   always_ff @(posedge clk) begin
      if (rst) begin
         r_len <= {LEN_W{1'b0}};
         r_cnt <= {LEN_W{1'b0}};
      end else if (w_accept) begin
         r_len <= len;
         r_cnt <= {LEN_W{1'b0}};
      end else if (w_xfer) begin
         r_cnt <= r_cnt + LEN_W'(1);
      end else begin
         r_len <= r_len;
         r_cnt <= r_cnt;
      end
   end

   // Running maximum and index of its first occurrence
   always_ff @(posedge clk) begin
      if (rst) begin
         r_max <= {WIDTH{1'b0}};
         r_idx <= {IDX_W{1'b0}};
      end else if (w_take) begin
         r_max <= in_data;
         r_idx <= r_cnt[IDX_W-1:0];
      end else begin
         r_max <= r_max;
         r_idx <= r_idx;
      end
   end

   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign out_max   = r_max;
   assign out_idx   = r_idx;
   assign busy      = r_busy;
   assign err       = r_err;

endmodule
